// File: rtl/poly_voice_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_voice_synth: polyphonic square/saw/triangle tone core, one mixed     |
// | sample per strobe. Optional macro: VOICE_STEAL_EN (steal oldest voice).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module poly_voice_synth #(
  parameter int NUM_KEYS   = 88,
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 16
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic                        iSAMPLE_STB,
  input  logic [NUM_KEYS-1:0]         iKEYS,
  input  logic [1:0]                  iWAVE_SEL,
  output logic [$clog2(NUM_KEYS)-1:0] oTUNE_ADDR,
  input  logic [PHASE_W-1:0]          iTUNE_DATA,
  output logic [SAMPLE_W-1:0]         oSAMPLE,
  output logic                        oSAMPLE_VALID,
  output logic [NUM_VOICES-1:0]       oACTIVE,
  output logic                        oKEY_PLAYED,
  output logic                        oOVERRUN
);

  localparam int c_KEY_W   = $clog2(NUM_KEYS);
  localparam int c_VOICE_W = $clog2(NUM_VOICES);
  localparam int c_SUM_W   = SAMPLE_W + c_VOICE_W;
  localparam logic [SAMPLE_W-1:0] c_AMP = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RELEASE = 3'd1,
    S_SCAN    = 3'd2,
    S_DRAIN   = 3'd3,
    S_ACCUM   = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_KEY_W-1:0]    r_k;
  logic [c_VOICE_W-1:0]  r_v;
  logic [NUM_VOICES-1:0] r_active;
  logic [c_KEY_W-1:0]    r_key   [NUM_VOICES];
  logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
  logic [PHASE_W-1:0]    r_inc   [NUM_VOICES];
  logic                  r_pend;
  logic [c_VOICE_W-1:0]  r_pend_v;
  logic [c_SUM_W-1:0]    r_sum;
  logic [SAMPLE_W-1:0]   r_sample;
  logic                  r_valid;
  logic                  r_overrun;

  logic                  w_held;
  logic                  w_free_ok;
  logic [c_VOICE_W-1:0]  w_free_v;
  logic                  w_claim_ok;
  logic [c_VOICE_W-1:0]  w_claim_v;
  logic [PHASE_W-1:0]    w_new_phase;
  logic [SAMPLE_W-1:0]   w_top;
  logic [SAMPLE_W-1:0]   w_fold;
  logic [SAMPLE_W-1:0]   w_wave;

  always_comb begin
    w_held = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (r_active[v] && (r_key[v] == r_k)) w_held = 1'b1;
  end

  always_comb begin
    w_free_ok = 1'b0;
    w_free_v  = '0;
    for (int v = NUM_VOICES-1; v >= 0; v--)
      if (!r_active[v]) begin
        w_free_ok = 1'b1;
        w_free_v  = c_VOICE_W'(v);
      end
  end

`ifdef VOICE_STEAL_EN
  // Stamps only grow, so the smallest stamp is the longest-held voice.
  logic [31:0]          r_age [NUM_VOICES];
  logic [31:0]          r_stamp;
  logic [31:0]          w_min_age;
  logic [c_VOICE_W-1:0] w_old_v;

  always_comb begin
    w_old_v   = '0;
    w_min_age = r_age[0];
    for (int v = 1; v < NUM_VOICES; v++)
      if (r_age[v] < w_min_age) begin
        w_min_age = r_age[v];
        w_old_v   = c_VOICE_W'(v);
      end
  end

  assign w_claim_ok = iKEYS[r_k] && !w_held;
  assign w_claim_v  = w_free_ok ? w_free_v : w_old_v;
`else
  assign w_claim_ok = iKEYS[r_k] && !w_held && w_free_ok;
  assign w_claim_v  = w_free_v;
`endif

  always_comb begin
    w_new_phase = r_phase[r_v] + r_inc[r_v];
    w_top       = w_new_phase[PHASE_W-1 -: SAMPLE_W];
    w_fold      = {w_top[SAMPLE_W-2:0], 1'b0};
    if (w_new_phase[PHASE_W-1]) w_fold = ~w_fold;
    w_wave = '0;
    if (r_active[r_v]) begin
      case (iWAVE_SEL)
        2'd0:    w_wave = w_new_phase[PHASE_W-1] ? (~c_AMP + 1'b1) : c_AMP;
        2'd1:    w_wave = {~w_top[SAMPLE_W-1], w_top[SAMPLE_W-2:0]};
        2'd2:    w_wave = {~w_fold[SAMPLE_W-1], w_fold[SAMPLE_W-2:0]};
        default: w_wave = '0;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_v       <= '0;
      r_active  <= '0;
      r_pend    <= 1'b0;
      r_pend_v  <= '0;
      r_sum     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_key[v]   <= '0;
        r_phase[v] <= '0;
        r_inc[v]   <= '0;
      end
`ifdef VOICE_STEAL_EN
      r_stamp <= '0;
      for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
      if (iSAMPLE_STB && (r_state != S_IDLE)) r_overrun <= 1'b1;
      // Tuning ROM answers one cycle after the claim that addressed it.
      if (r_pend) r_inc[r_pend_v] <= iTUNE_DATA;

      case (r_state)
        S_IDLE: begin
          if (iSAMPLE_STB) r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          for (int v = 0; v < NUM_VOICES; v++)
            if (r_active[v] && !iKEYS[r_key[v]]) r_active[v] <= 1'b0;
          r_k     <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_claim_ok) begin
            r_active[w_claim_v] <= 1'b1;
            r_key[w_claim_v]    <= r_k;
            r_phase[w_claim_v]  <= '0;
            r_pend              <= 1'b1;
            r_pend_v            <= w_claim_v;
`ifdef VOICE_STEAL_EN
            r_age[w_claim_v]    <= r_stamp;
            r_stamp             <= r_stamp + 32'd1;
`endif
          end
          if (r_k == c_KEY_W'(NUM_KEYS-1)) r_state <= S_DRAIN;
          else                             r_k     <= r_k + 1'b1;
        end
        S_DRAIN: begin
          r_sum   <= '0;
          r_v     <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (r_active[r_v]) r_phase[r_v] <= w_new_phase;
          r_sum <= r_sum + {{c_VOICE_W{w_wave[SAMPLE_W-1]}}, w_wave};
          if (r_v == c_VOICE_W'(NUM_VOICES-1)) r_state <= S_OUT;
          else                                 r_v     <= r_v + 1'b1;
        end
        S_OUT: begin
          r_sample <= r_sum[c_SUM_W-1:c_VOICE_W];
          r_valid  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oTUNE_ADDR    = r_k;
  assign oSAMPLE       = r_sample;
  assign oSAMPLE_VALID = r_valid;
  assign oACTIVE       = r_active;
  assign oKEY_PLAYED   = |r_active;
  assign oOVERRUN      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_poly_voice_synth: randomized bench with a behavioural voice model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_poly_voice_synth;

  localparam int NK   = 88;
  localparam int NV   = 4;
  localparam int PW   = 24;
  localparam int SW   = 16;
  localparam int AMP  = 32767;
  localparam int HALF = 32768;
  localparam int FULL = 65536;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb;
  logic [NK-1:0] keys;
  logic [1:0]    wsel;
  logic [6:0]    tune_addr;
  logic [PW-1:0] tune_data;
  logic [SW-1:0] sample;
  logic          valid;
  logic [NV-1:0] active;
  logic          played;
  logic          overrun;

  logic [PW-1:0] rom [NK];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit [NV-1:0]   m_act;
  int            m_key   [NV];
  int unsigned   m_phase [NV];
  int unsigned   m_inc   [NV];
  int            m_age   [NV];
  int            m_stamp;
  bit            m_ovr;
  logic [SW-1:0] m_exp;

  poly_voice_synth dut (
    .iCLK          (clk),
    .iRST_N        (rst_n),
    .iSAMPLE_STB   (stb),
    .iKEYS         (keys),
    .iWAVE_SEL     (wsel),
    .oTUNE_ADDR    (tune_addr),
    .iTUNE_DATA    (tune_data),
    .oSAMPLE       (sample),
    .oSAMPLE_VALID (valid),
    .oACTIVE       (active),
    .oKEY_PLAYED   (played),
    .oOVERRUN      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tune_data <= rom[tune_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wave(input logic [1:0] sel, input int unsigned p);
    int unsigned t, u;
    bit hi;
    t  = p >> (PW - SW);
    hi = p[PW-1];
    case (sel)
      2'd0: return hi ? -AMP : AMP;
      2'd1: return int'(t) - HALF;
      2'd2: begin
        u = (t * 2) % FULL;
        if (hi) u = FULL - 1 - u;
        return int'(u) - HALF;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_act = '0;
    m_stamp = 0;
    m_ovr = 1'b0;
    for (int v = 0; v < NV; v++) begin
      m_key[v] = 0; m_phase[v] = 0; m_inc[v] = 0; m_age[v] = 0;
    end
  endtask

  // One sample period: release, allocate keys low to high, advance and mix.
  task automatic model_sample(input logic [NK-1:0] k_in, input logic [1:0] s_in);
    int sum, fv;
    bit held;
    for (int v = 0; v < NV; v++)
      if (m_act[v] && !k_in[m_key[v]]) m_act[v] = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (k_in[k]) begin
        held = 1'b0;
        for (int v = 0; v < NV; v++) if (m_act[v] && m_key[v] == k) held = 1'b1;
        if (!held) begin
          fv = -1;
          for (int v = NV-1; v >= 0; v--) if (!m_act[v]) fv = v;
`ifdef VOICE_STEAL_EN
          if (fv < 0) begin
            fv = 0;
            for (int v = 1; v < NV; v++) if (m_age[v] < m_age[fv]) fv = v;
          end
`endif
          if (fv >= 0) begin
            m_act[fv] = 1'b1; m_key[fv] = k; m_phase[fv] = 0;
            m_inc[fv] = rom[k]; m_age[fv] = m_stamp; m_stamp++;
          end
        end
      end
    end
    sum = 0;
    for (int v = 0; v < NV; v++)
      if (m_act[v]) begin
        m_phase[v] = (m_phase[v] + m_inc[v]) & ((1 << PW) - 1);
        sum += wave(s_in, m_phase[v]);
      end
    m_exp = SW'(sum >>> 2);
  endtask

  task automatic run_sample(input logic [NK-1:0] k_in, input logic [1:0] s_in, input int gap);
    int n;
    keys = k_in;
    wsel = s_in;
    model_sample(k_in, s_in);
    stb = 1'b1; tick(); stb = 1'b0;
    n = 0;
    while (!valid && n < 200) begin tick(); n++; end
    chk("latency", n, 95);
    chk("sample", sample, m_exp);
    chk("active", active, m_act);
    chk("played", played, |m_act);
    chk("overrun", overrun, m_ovr);
    tick();
    chk("valid_pulse", valid, 0);
    repeat (gap) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_played"}, played, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_addr"}, tune_addr, 0);
  endtask

  task automatic do_reset();
    int nv;
    rst_n = 1'b0; stb = 1'b1;
    repeat (3) tick();
    stb = 1'b0;
    check_zero("rst");
    rst_n = 1'b1;
    nv = 0;
    repeat (120) begin tick(); if (valid) nv++; end
    chk("rst_no_valid", nv, 0);
    model_reset();
  endtask

  task automatic overrun_test();
    int nv;
    logic [SW-1:0] got;
    got = '0;
    model_sample(keys, wsel);
    stb = 1'b1; tick(); stb = 1'b0;
    nv = 0;
    for (int c = 1; c <= 200; c++) begin
      stb = (c == 10);
      tick();
      if (valid) begin nv++; if (nv == 1) got = sample; end
    end
    stb = 1'b0;
    chk("ovr_valid_count", nv, 1);
    chk("ovr_sample", got, m_exp);
    chk("ovr_flag", overrun, 1);
    m_ovr = 1'b1;
    run_sample(keys, wsel, 3);
  endtask

  task automatic midscan_reset();
    int n, nv;
    stb = 1'b1; tick(); stb = 1'b0;
    n = 0;
    while (tune_addr != 7'd30 && n < 200) begin tick(); n++; end
    chk("scan_reached_30", tune_addr, 30);
    rst_n = 1'b0;
    tick();
    check_zero("midscan");
    rst_n = 1'b1;
    nv = 0;
    repeat (150) begin tick(); if (valid) nv++; end
    chk("midscan_no_valid", nv, 0);
    model_reset();
  endtask

  initial begin
    logic [NK-1:0] k;
    rst_n = 1'b0; stb = 1'b0; keys = '0; wsel = 2'd0;
    for (int i = 0; i < NK; i++) rom[i] = PW'($urandom);
    rom[40] = 24'h010000;
    model_reset();

    do_reset();

    // Single key 40, square: +0x1FFF until phase MSB sets at strobe 128.
    k = '0; k[40] = 1'b1;
    for (int s = 1; s <= 128; s++) begin
      run_sample(k, 2'd0, 2);
      if (s == 1) begin
        chk("t2_first", sample, 16'h1FFF);
        chk("t2_active", active, 4'b0001);
      end
      if (s == 127) chk("t2_127", sample, 16'h1FFF);
      if (s == 128) chk("t2_128", sample, 16'hE000);
    end

    // Release key 40: everything goes quiet.
    run_sample('0, 2'd0, 2);
    chk("t5_active", active, 0);
    chk("t5_played", played, 0);
    chk("t5_sample", sample, 0);

    // Five keys, four voices.
    k = '0; k[10] = 1'b1; k[20] = 1'b1; k[30] = 1'b1; k[40] = 1'b1; k[50] = 1'b1;
    run_sample(k, 2'($urandom_range(0, 2)), 2);
    chk("t3_active", active, 4'b1111);
    run_sample(k, 2'd1, 2);

    // Randomized key patterns and waveforms.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 7) == 0) k = '0;
      repeat ($urandom_range(1, 3)) k[$urandom_range(0, NK-1)] ^= 1'b1;
      run_sample(k, 2'($urandom), $urandom_range(0, 20));
    end

    overrun_test();
    do_reset();

    k = '0; k[5] = 1'b1; k[70] = 1'b1;
    run_sample(k, 2'd2, 2);
    midscan_reset();
    for (int it = 0; it < 10; it++) begin
      k[$urandom_range(0, NK-1)] ^= 1'b1;
      run_sample(k, 2'($urandom), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
